// File: rtl/ram_sync.sv
// ram_sync: single-port synchronous RAM with registered read port and reset-launched clear sequencer.
module ram_sync #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter bit CLEAR_ON_RESET = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] dataIn,
    input  logic                  writeEnable,
    input  logic                  readEnable,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  readValid,
    output logic                  busy
);
    localparam int DEPTH = 2**ADDR_WIDTH;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                  state, stateNext;
    logic [ADDR_WIDTH-1:0]   clearAddr;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic                    memWrite, doRead;
    logic [ADDR_WIDTH-1:0]   memAddr;
    logic [DATA_WIDTH-1:0]   memData;

    always_ff @(posedge clock)
        state <= stateNext;

    // The clear sequencer owns the write port while walking; user requests are dropped.
    always_comb begin
        stateNext = state;
        memWrite  = 1'b0;
        memAddr   = address;
        memData   = dataIn;
        doRead    = 1'b0;
        if (reset)
            stateNext = CLEAR_ON_RESET ? CLEAR : IDLE;
        else if (state == CLEAR) begin
            memWrite  = 1'b1;
            memAddr   = clearAddr;
            memData   = '0;
            stateNext = &clearAddr ? IDLE : CLEAR;
        end else begin
            memWrite = writeEnable;
            doRead   = readEnable;
        end
    end

    always_ff @(posedge clock)
        if (reset)
            clearAddr <= '0;
        else if (state == CLEAR)
            clearAddr <= clearAddr + 1'b1;

    always_ff @(posedge clock)
        if (memWrite)
            mem[memAddr] <= memData;

    // Read-first: the read samples the word before this edge's write lands.
    always_ff @(posedge clock)
        if (reset) begin
            dataOut   <= '0;
            readValid <= 1'b0;
        end else begin
            readValid <= doRead;
            if (doRead)
                dataOut <= mem[address];
        end

    assign busy = (state == CLEAR);
endmodule
